tiny_dnn_axil_seq: RTL and testbench
====================================

// Module: tiny_dnn_axil_seq
// PURPOSE
// - AXI4-Lite master that sits directly upstream of the weight-RAM/MAC slave and drives its register map.
// - LOAD command streams 16-bit weights into RAM words; DOT command streams activations into the MAC window (0x8000|idx<<2).
// - The slave's accumulator has no clear. DOT therefore reads the sum before and after the burst and returns post-pre (mod 2^16).
// PARAMETERS
// - IDX_W     13         RAM word-index width (8192 words)
// - DATA_W    16         weight/activation/result width
// - MAC_BASE  32'h8000   MAC window base; also the sum read address
// PORTS
// - M_AXI_ACLK     in   1       single clock, all logic posedge
// - M_AXI_ARESET   in   1       synchronous, active-high reset
// - cmd_valid/cmd_ready  in/out  1   command handshake
// - cmd_op         in   1       0=LOAD, 1=DOT
// - cmd_base       in   IDX_W   first word index
// - cmd_len        in   IDX_W   word count; 0 is legal
// - din_valid/din_ready  in/out  1   operand stream handshake
// - din_data       in   DATA_W  weight (LOAD) or activation (DOT)
// - res_valid/res_ready  out/in  1   DOT result handshake
// - res_data       out  DATA_W  post_sum - pre_sum, 16-bit wrap
// - busy           out  1       high whenever state != IDLE
// - M_AXI_AW{ADDR[31:0],VALID,READY}, W{DATA[31:0],STRB[3:0],VALID,READY}, B{RESP[1:0],VALID,READY}: standard AXI-Lite write channels
// - M_AXI_AR{ADDR[31:0],VALID,READY}, R{DATA[31:0],RESP[1:0],VALID,READY}: standard AXI-Lite read channels
// BEHAVIOUR
// - Reset values: all VALID/READY outputs 0, busy 0, res_data 0, addresses/data 0, state IDLE.
// - Reset mid-operation aborts the command immediately and asserts no further transactions. The slave is not reset by this block.
// - cmd_ready = (state==IDLE). A command is accepted on cmd_valid&cmd_ready; op, base and len are latched; i=0.
// - States: IDLE, PRE_AR, PRE_R, FETCH, WR, WB, POST_AR, POST_R, RESULT.
// - LOAD path: IDLE->FETCH. DOT path: IDLE->PRE_AR.
// - PRE_AR: ARVALID=1, ARADDR=MAC_BASE; on ARREADY -> PRE_R.
// - PRE_R: RREADY=1; on RVALID capture pre=RDATA[15:0] -> FETCH.
// - FETCH: if i==len -> POST_AR (DOT) or IDLE (LOAD). Otherwise din_ready=1; on din_valid latch din_data -> WR.
// - WR: AWVALID and WVALID rise together.
//   - Each VALID drops independently after its own handshake; the AW and W handshakes may land in the same or different cycles.
//   - When both are done -> WB.
// - Addresses: AWADDR = {16'h0, op, (base+i) mod 2^IDX_W, 2'b00}. The index wraps 8191->0.
// - Write data: WDATA = {16'h0, data}, WSTRB=4'hF.
// - WDATA stays stable from WR through the B handshake, because the slave samples WDATA in its response cycle.
// - WB: BREADY=1; on BVALID, i++ -> FETCH. BRESP is ignored.
// - POST_AR/POST_R: same as the PRE states, capturing post -> RESULT.
// - RESULT: res_valid=1, res_data=post-pre, held stable until res_ready, then -> IDLE.
// - Exactly one AXI transaction is outstanding at any time. AR and AW are never concurrent.
// - LOAD with len=0 returns to IDLE with no bus traffic. DOT with len=0 performs both reads and returns res_data=0 (absent other masters).
// - Throughput: no more than one operand per 3 cycles; minimum latency din accept->din_ready again = 3 cycles with zero-wait slave.
// STRUCTURE
// - Shared package tiny_dnn_pkg: OP_LOAD/OP_DOT, state enum, MAC_BASE, IDX_W, DATA_W.
// - One sub-module, tiny_dnn_axil_wr_chan: independent AW/W valid tracking plus B wait, with start/done ports.
// - Read channel and FSM inline, ~250 lines total.
// TESTING (bench instantiates the weight-RAM/MAC slave as the DUT's target)
// - LOAD base=0 len=3 din=1,2,3 -> writes to 0x0,0x4,0x8 with WDATA 1,2,3; no res_valid; busy falls after the 3rd B.
// - DOT base=0 len=3 din=4,5,6 (after the LOAD above):
//   - bus order: AR 0x8000, then AW 0x8000/0x8004/0x8008, then AR 0x8000;
//   - result: res_data=32 (0x0020).
// - Repeat the same DOT -> res_data=32 again, although the slave sum is now 64.
// - Backpressure:
//   - din_valid gaps of 4 cycles and res_ready held low 5 cycles -> res_data stable;
//   - cmd_ready stays low while busy;
//   - no duplicate writes.
// - Edge cases:
//   - LOAD base=8191 len=2 din=7,9 -> AWADDR 0x7FFC then 0x0000;
//   - DOT len=0 -> exactly 2 reads, res_data=0.
// - Reset mid-operation: assert M_AXI_ARESET during the WR of the 2nd DOT operand.
//   - Next cycle: all VALIDs 0, busy 0.
//   - A following DOT completes correctly as a post-pre delta.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny DNN AXI-Lite sequencer: opcodes, FSM states,
// register-map constants and the write-address encoder.
package tiny_dnn_pkg;
    localparam int          IDX_W    = 13;
    localparam int          DATA_W   = 16;
    localparam logic [31:0] MAC_BASE = 32'h0000_8000;
    localparam logic        OP_LOAD  = 1'b0;
    localparam logic        OP_DOT   = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_AR,
        S_PRE_R,
        S_FETCH,
        S_WR,
        S_WB,
        S_POST_AR,
        S_POST_R,
        S_RESULT
    } state_t;

    // The op bit lands on address bit 15, so DOT writes fall in the MAC window.
    function automatic logic [31:0] wr_addr(input logic op, input logic [IDX_W-1:0] idx);
        return {16'h0000, op, idx, 2'b00};
    endfunction
endpackage

// File: rtl/tiny_dnn_axil_wr_chan.sv
// AXI-Lite write channel helper: raises AW and W together on start, retires
// each VALID independently, then waits for the write response.
module tiny_dnn_axil_wr_chan (
    input  logic M_AXI_ACLK,
    input  logic M_AXI_ARESET,
    input  logic start,
    output logic awvalid,
    input  logic awready,
    output logic wvalid,
    input  logic wready,
    input  logic bvalid,
    output logic bready,
    output logic addr_done,
    output logic done
);
    logic aw_fin;
    logic w_fin;

    assign aw_fin    = !awvalid || awready;
    assign w_fin     = !wvalid || wready;
    assign addr_done = (awvalid || wvalid) && aw_fin && w_fin;
    assign done      = bready && bvalid;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (addr_done)          bready  <= 1'b1;
            else if (done)          bready  <= 1'b0;
        end
    end
endmodule

// File: rtl/tiny_dnn_axil_seq.sv
// AXI-Lite master sequencing LOAD (weight writes) and DOT (MAC writes bracketed
// by accumulator reads) commands towards the weight-RAM/MAC slave.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a command
// PRE_AR    | DOT: issue accumulator read before the burst
// PRE_R     | DOT: capture pre-burst accumulator value
// FETCH     | take next operand or finish when i == len
// WR        | AW and W in flight
// WB        | waiting for write response
// POST_AR   | DOT: issue accumulator read after the burst
// POST_R    | DOT: capture post-burst value, form the delta
// RESULT    | present delta until res_ready
module tiny_dnn_axil_seq
    import tiny_dnn_pkg::*;
(
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [IDX_W-1:0]  cmd_base,
    input  logic [IDX_W-1:0]  cmd_len,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic [31:0]       M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [31:0]       M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t              state, state_nx;
    logic                op_q;
    logic [IDX_W-1:0]    base_q, len_q, idx_cnt;
    logic [DATA_W-1:0]   pre_q, res_q, wdata_q;
    logic [31:0]         awaddr_q;
    logic                wr_start, wr_addr_done, wr_done;
    logic                unused_in;

    assign unused_in = ^{M_AXI_BRESP, M_AXI_RRESP, M_AXI_RDATA[31:DATA_W]};

    tiny_dnn_axil_wr_chan u_wr_chan (
        .M_AXI_ACLK   (M_AXI_ACLK),
        .M_AXI_ARESET (M_AXI_ARESET),
        .start        (wr_start),
        .awvalid      (M_AXI_AWVALID),
        .awready      (M_AXI_AWREADY),
        .wvalid       (M_AXI_WVALID),
        .wready       (M_AXI_WREADY),
        .bvalid       (M_AXI_BVALID),
        .bready       (M_AXI_BREADY),
        .addr_done    (wr_addr_done),
        .done         (wr_done)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) state <= S_IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        wr_start      = 1'b0;
        cmd_ready     = (state == S_IDLE);
        din_ready     = 1'b0;
        res_valid     = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_nx = (cmd_op == OP_DOT) ? S_PRE_AR : S_FETCH;
            S_PRE_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nx = S_PRE_R;
            end
            S_PRE_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (idx_cnt == len_q) begin
                    state_nx = (op_q == OP_DOT) ? S_POST_AR : S_IDLE;
                end else begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        wr_start = 1'b1;
                        state_nx = S_WR;
                    end
                end
            end
            S_WR: if (wr_addr_done) state_nx = S_WB;
            S_WB: if (wr_done) state_nx = S_FETCH;
            S_POST_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nx = S_POST_R;
            end
            S_POST_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_nx = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // WDATA is held from operand accept until the next one: the slave samples it at B.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            op_q     <= OP_LOAD;
            base_q   <= '0;
            len_q    <= '0;
            idx_cnt  <= '0;
            pre_q    <= '0;
            res_q    <= '0;
            wdata_q  <= '0;
            awaddr_q <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_q    <= cmd_op;
                base_q  <= cmd_base;
                len_q   <= cmd_len;
                idx_cnt <= '0;
            end
            if (state == S_PRE_R && M_AXI_RVALID) pre_q <= M_AXI_RDATA[DATA_W-1:0];
            if (wr_start) begin
                awaddr_q <= wr_addr(op_q, base_q + idx_cnt);
                wdata_q  <= din_data;
            end
            if (wr_done) idx_cnt <= idx_cnt + IDX_ONE;
            if (state == S_POST_R && M_AXI_RVALID) res_q <= M_AXI_RDATA[DATA_W-1:0] - pre_q;
        end
    end

    assign busy         = (state != S_IDLE);
    assign res_data     = res_q;
    assign M_AXI_AWADDR = awaddr_q;
    assign M_AXI_WDATA  = {{(32-DATA_W){1'b0}}, wdata_q};
    assign M_AXI_WSTRB  = 4'hF;
    assign M_AXI_ARADDR = M_AXI_ARVALID ? MAC_BASE : 32'h0;
endmodule

// File: tb/tb_tiny_dnn_axil_seq.sv
// Bench for tiny_dnn_axil_seq: a weight-RAM/MAC slave model on the bus and a
// scoreboard of expected AR/B events checked as the slave sees them.
module tb_tiny_dnn_axil_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [12:0] cmd_base, cmd_len;
    logic        din_valid, din_ready;
    logic [15:0] din_data;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ram [0:8191];
    logic [31:0] acc;
    logic        aw_got, w_got;
    logic [31:0] aw_a, b_addr;
    bit          slow = 1'b0;
    int          n_b = 0, n_ar = 0, n_overlap = 0;
    logic [55:0] exp_q[$];

    int          mram [0:8191];
    logic [15:0] din_vec [0:15];

    bit          r_timeout, r_unstable, r_saw_res, r_cmd_viol;
    int          r_min_iv, r_nb;
    logic [15:0] r_res;

    assign bresp = 2'b00;
    assign rresp = 2'b00;

    always #5 clk = ~clk;

    tiny_dnn_axil_seq dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave ready signals change on the falling edge; slow mode inserts random waits.
    always @(negedge clk) begin
        awready = !aw_got && !bvalid && (!slow || $urandom_range(0, 1) == 1);
        wready  = !w_got && !bvalid && (!slow || $urandom_range(0, 1) == 1);
        arready = !rvalid && (!slow || $urandom_range(0, 1) == 1);
    end

    always @(posedge clk) begin
        logic [55:0] ev, exp_ev;
        bit have;
        have = 1'b0;
        ev = '0;
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            if (arvalid && (awvalid || wvalid || bready)) n_overlap++;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
            if (wvalid && wready) w_got <= 1'b1;
            if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_addr <= aw_got ? aw_a : awaddr;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                if (b_addr[15]) acc <= acc + 32'(ram[b_addr[14:2]]) * 32'(wdata[15:0]);
                else            ram[b_addr[14:2]] <= wdata[15:0];
                ev = {8'h02, b_addr, wdata[15:0]};
                have = 1'b1;
                n_b++;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= acc;
                ev = {8'h01, araddr, 16'h0000};
                have = 1'b1;
                n_ar++;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (have) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_event: got %h, required no transaction", ev);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (ev !== exp_ev) begin
                        miscompares++;
                        $display("FAIL bus_event: got %h, required %h", ev, exp_ev);
                    end
                end
            end
        end
    end

    // Pushes the bus events a command must produce and updates the RAM model.
    task automatic expect_cmd(input logic op, input int base, input int len, output logic [15:0] res);
        int sum, idx;
        logic [31:0] a;
        sum = 0;
        if (op) exp_q.push_back({8'h01, 32'h0000_8000, 16'h0000});
        for (int k = 0; k < len; k++) begin
            idx = (base + k) % 8192;
            a = 32'(idx) << 2;
            if (op) a = a | 32'h0000_8000;
            exp_q.push_back({8'h02, a, din_vec[k]});
            if (op) sum += mram[idx] * int'(din_vec[k]);
            else    mram[idx] = int'(din_vec[k]);
        end
        if (op) exp_q.push_back({8'h01, 32'h0000_8000, 16'h0000});
        res = 16'(sum);
    endtask

    task automatic run_cmd(input logic op, input int base, input int len, input int gap, input int hold);
        int k, gapc, holdc, last_c, nb0;
        bit fire_d, fire_r, first_seen, fin;
        logic [15:0] first_val;
        k = 0; gapc = 0; holdc = 0; last_c = -1; nb0 = n_b;
        fire_d = 0; fire_r = 0; first_seen = 0; fin = 0; first_val = '0;
        r_timeout = 0; r_unstable = 0; r_saw_res = 0; r_cmd_viol = 0;
        r_min_iv = 1000; r_nb = 0; r_res = 16'hDEAD;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_base = 13'(base); cmd_len = 13'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (fire_d) begin
                if (last_c >= 0 && c - last_c < r_min_iv) r_min_iv = c - last_c;
                last_c = c;
                k++;
                gapc = gap;
            end
            if (fire_r || !busy) begin
                fin = 1;
                r_nb = n_b - nb0;
            end else begin
                if (cmd_ready) r_cmd_viol = 1;
                if (k < len && gapc == 0) begin
                    din_valid = 1'b1;
                    din_data = din_vec[k];
                end else begin
                    din_valid = 1'b0;
                    if (gapc > 0) gapc--;
                end
                if (res_valid) begin
                    r_saw_res = 1;
                    if (!first_seen) begin first_seen = 1; first_val = res_data; end
                    else if (res_data !== first_val) r_unstable = 1;
                    if (holdc < hold) begin holdc++; res_ready = 1'b0; end
                    else begin res_ready = 1'b1; r_res = res_data; end
                end else begin
                    res_ready = 1'b0;
                end
                fire_d = din_valid && din_ready;
                fire_r = res_valid && res_ready;
            end
        end
        din_valid = 1'b0;
        res_ready = 1'b0;
        if (!fin) r_timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({awvalid, wvalid, arvalid, bready, rready, res_valid, busy, din_ready} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {awvalid, wvalid, arvalid, bready, rready, res_valid, busy, din_ready});
        end
        vectors++;
        if ({awaddr, wdata, araddr, res_data} !== 112'h0) begin
            miscompares++;
            $display("FAIL reset_data: got aw=%h w=%h ar=%h res=%h, required all 0", awaddr, wdata, araddr, res_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_load();
        logic [15:0] e;
        din_vec[0] = 16'd1; din_vec[1] = 16'd2; din_vec[2] = 16'd3;
        expect_cmd(1'b0, 0, 3, e);
        run_cmd(1'b0, 0, 3, 0, 0);
        vectors++;
        if (r_timeout || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL load_complete: timeout=%0d pending=%0d, required 0 and 0", r_timeout, exp_q.size());
        end
        vectors++;
        if (r_saw_res) begin miscompares++; $display("FAIL load_no_result: got res_valid=1, required 0"); end
        vectors++;
        if (r_min_iv != 3) begin miscompares++; $display("FAIL load_throughput: got %0d cycles, required 3", r_min_iv); end
        vectors++;
        if (r_nb != 3) begin miscompares++; $display("FAIL load_b_before_idle: got %0d, required 3", r_nb); end
        vectors++;
        if (wstrb !== 4'hF) begin miscompares++; $display("FAIL load_wstrb: got %h, required f", wstrb); end
    endtask

    task automatic test_dot(input string name);
        logic [15:0] e;
        din_vec[0] = 16'd4; din_vec[1] = 16'd5; din_vec[2] = 16'd6;
        expect_cmd(1'b1, 0, 3, e);
        run_cmd(1'b1, 0, 3, 0, 0);
        vectors++;
        if (r_timeout || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_complete: timeout=%0d pending=%0d, required 0 and 0", name, r_timeout, exp_q.size());
        end
        vectors++;
        if (r_res !== e) begin miscompares++; $display("FAIL %s_result: got %h, required %h", name, r_res, e); end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        slow = 1'b1;
        din_vec[0] = 16'd1; din_vec[1] = 16'd2; din_vec[2] = 16'd3;
        expect_cmd(1'b0, 0, 3, e);
        run_cmd(1'b0, 0, 3, 4, 0);
        vectors++;
        if (r_timeout || exp_q.size() != 0 || r_cmd_viol) begin
            miscompares++;
            $display("FAIL bp_load: timeout=%0d pending=%0d cmd_ready_busy=%0d, required 0 0 0",
                     r_timeout, exp_q.size(), r_cmd_viol);
        end
        din_vec[0] = 16'd4; din_vec[1] = 16'd5; din_vec[2] = 16'd6;
        expect_cmd(1'b1, 0, 3, e);
        run_cmd(1'b1, 0, 3, 4, 5);
        vectors++;
        if (r_timeout || exp_q.size() != 0 || r_cmd_viol) begin
            miscompares++;
            $display("FAIL bp_dot: timeout=%0d pending=%0d cmd_ready_busy=%0d, required 0 0 0",
                     r_timeout, exp_q.size(), r_cmd_viol);
        end
        vectors++;
        if (r_unstable) begin miscompares++; $display("FAIL bp_res_stable: got changing res_data, required stable"); end
        vectors++;
        if (r_res !== e) begin miscompares++; $display("FAIL bp_result: got %h, required %h", r_res, e); end
        slow = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        din_vec[0] = 16'd7; din_vec[1] = 16'd9;
        expect_cmd(1'b0, 8191, 2, e);
        run_cmd(1'b0, 8191, 2, 0, 0);
        vectors++;
        if (r_timeout || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_load: timeout=%0d pending=%0d, required 0 and 0", r_timeout, exp_q.size());
        end
    endtask

    task automatic test_dot_len0();
        logic [15:0] e;
        int ar0;
        ar0 = n_ar;
        expect_cmd(1'b1, 5, 0, e);
        run_cmd(1'b1, 5, 0, 0, 0);
        vectors++;
        if (r_timeout || exp_q.size() != 0 || n_ar - ar0 != 2) begin
            miscompares++;
            $display("FAIL dot_len0_reads: timeout=%0d pending=%0d reads=%0d, required 0 0 2",
                     r_timeout, exp_q.size(), n_ar - ar0);
        end
        vectors++;
        if (r_res !== 16'h0000) begin miscompares++; $display("FAIL dot_len0_result: got %h, required 0000", r_res); end
    endtask

    task automatic test_reset_mid();
        int k;
        bit fire;
        din_vec[0] = 16'd4; din_vec[1] = 16'd5; din_vec[2] = 16'd6;
        exp_q.push_back({8'h01, 32'h0000_8000, 16'h0000});
        exp_q.push_back({8'h02, 32'h0000_8000, din_vec[0]});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 13'd0; cmd_len = 13'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && k < 2; c++) begin
            din_valid = 1'b1;
            din_data = din_vec[k];
            fire = din_ready;
            @(negedge clk);
            if (fire) k++;
        end
        din_valid = 1'b0;
        vectors++;
        if (k != 2 || awvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_reach_wr: got accepts=%0d awvalid=%b, required 2 and 1", k, awvalid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({awvalid, wvalid, arvalid, bready, rready, res_valid, busy} !== 7'h00) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got %b, required 0000000",
                     {awvalid, wvalid, arvalid, bready, rready, res_valid, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_traffic: got %0d pending events, required 0", exp_q.size());
        end
        test_dot("dot_after_rst");
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram[i] = 16'h0000;
            mram[i] = 0;
        end
        acc = 32'h0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
        din_valid = 1'b0; din_data = '0; res_ready = 1'b0;
        test_reset();
        test_load();
        test_dot("dot_first");
        test_dot("dot_repeat");
        vectors++;
        if (acc !== 32'd64) begin miscompares++; $display("FAIL slave_sum: got %0d, required 64", acc); end
        test_backpressure();
        test_wrap();
        test_dot_len0();
        test_reset_mid();
        vectors++;
        if (n_overlap != 0) begin
            miscompares++;
            $display("FAIL ar_aw_overlap: got %0d cycles, required 0", n_overlap);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
